mac_column_seq: RTL and testbench

MAC_COLUMN_SEQ -- requirements
Module: mac_column_seq

---
 rtl/mac_pkg.sv | 54 +++++
 rtl/MAC_column.sv | 45 ++++
 rtl/mac_column_seq.sv | 163 ++++++++++++++++
 tb/tb_mac_column_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, encodings and mode decode for the column MAC sequencer.
// Column psum is 19 bits signed; the accumulator adds 3 guard bits.
package mac_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int COLUMN_NUM       = 6;
  localparam int OUT_WIDTH        = 22;
  localparam int COLUMN_OUT_WIDTH = 19;

  typedef logic [2:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_4X3X3 = 2'b00,
    MODE_4X4   = 2'b01,
    MODE_5X5   = 2'b10,
    MODE_6X6   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Columns per window.
  function automatic cnt_t mode_k(input mode_e m);
    cnt_t k;
    k = 3'd3;
    case (m)
      MODE_4X3X3: k = 3'd3;
      MODE_4X4:   k = 3'd4;
      MODE_5X5:   k = 3'd5;
      MODE_6X6:   k = 3'd6;
      default:    k = 3'd3;
    endcase
    return k;
  endfunction

  // Elements of a column that take part in the sum.
  function automatic cnt_t mode_rows(input mode_e m);
    cnt_t r;
    r = 3'd6;
    case (m)
      MODE_4X3X3: r = 3'd6;
      MODE_4X4:   r = 3'd4;
      MODE_5X5:   r = 3'd5;
      MODE_6X6:   r = 3'd6;
      default:    r = 3'd6;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/MAC_column.sv
// One column of unsigned-image x signed-weight products, summed.
// Elements beyond the mode's row count are masked to zero.
module MAC_column #(
  parameter int DATA_WIDTH       = mac_pkg::DATA_WIDTH,
  parameter int COLUMN_NUM       = mac_pkg::COLUMN_NUM,
  parameter int COLUMN_OUT_WIDTH = mac_pkg::COLUMN_OUT_WIDTH
) (
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] img,
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] wgt,
  input  mac_pkg::mode_e                   mode,
  output logic signed [COLUMN_OUT_WIDTH-1:0] psum
);
  import mac_pkg::*;

  localparam int PW = 2 * DATA_WIDTH + 1;

  cnt_t rows;
  logic signed [PW-1:0] prod [COLUMN_NUM];
  logic signed [COLUMN_OUT_WIDTH-1:0] sum;

  assign rows = mode_rows(mode);

  for (genvar i = 0; i < COLUMN_NUM; i++) begin : g_mul
    logic signed [DATA_WIDTH:0]   a;
    logic signed [DATA_WIDTH-1:0] b;
    logic signed [PW-1:0]         full;
    logic                         en;
    assign a    = {1'b0, img[i*DATA_WIDTH +: DATA_WIDTH]};
    assign b    = wgt[i*DATA_WIDTH +: DATA_WIDTH];
    assign full = a * b;
    assign en   = cnt_t'(i) < rows;
    assign prod[i] = en ? full : '0;
  end

  // Sign-extend each product and add them up.
  always_comb begin
    sum = '0;
    for (int i = 0; i < COLUMN_NUM; i++) begin
      sum = sum + {{(COLUMN_OUT_WIDTH-PW){prod[i][PW-1]}}, prod[i]};
    end
  end

  assign psum = sum;

endmodule

// File: rtl/mac_column_seq.sv
// Column-serial window MAC: accepts K columns per window, accumulates
// their psums and hands out one signed sum per window with backpressure.
module mac_column_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int COLUMN_NUM    = 6,
  parameter int ACC_WIDTH     = 22,
  parameter int WIN_CNT_WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [1:0]                     i_mode,
  input  logic [WIN_CNT_WIDTH-1:0]       i_num_windows,
  input  logic                           i_col_valid,
  output logic                           o_col_ready,
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_img_column,
  input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_wgt_column,
  output logic                           o_acc_valid,
  input  logic                           i_acc_ready,
  output logic [ACC_WIDTH-1:0]           o_acc,
  output logic                           o_busy,
  output logic                           o_done
);
  import mac_pkg::*;

  localparam int CW = COLUMN_OUT_WIDTH;

  state_e state;
  mode_e  mode_q;
  logic [WIN_CNT_WIDTH-1:0] num_win_q;
  logic [WIN_CNT_WIDTH-1:0] win_cnt;
  cnt_t   col_cnt;

  logic   accept;
  logic   col_last;
  logic   win_last;
  logic   res_take;

  logic   s1_valid;
  logic   s1_first;
  logic   s1_last;
  mode_e  s1_mode;
  logic [DATA_WIDTH*COLUMN_NUM-1:0] s1_img;
  logic [DATA_WIDTH*COLUMN_NUM-1:0] s1_wgt;

  logic signed [CW-1:0]        psum;
  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sum;

  assign o_col_ready = (state == ST_RUN) && !(o_acc_valid && !i_acc_ready);
  assign accept      = i_col_valid && o_col_ready;
  assign res_take    = o_acc_valid && i_acc_ready;
  assign col_last    = col_cnt == (mode_k(mode_q) - 3'd1);
  assign win_last    = win_cnt == (num_win_q - WIN_CNT_WIDTH'(1));

  // Job control: state, latched job parameters and column/window counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_4X3X3;
      num_win_q <= '0;
      win_cnt   <= '0;
      col_cnt   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && (i_num_windows != '0)) begin
            state     <= ST_RUN;
            mode_q    <= mode_e'(i_mode);
            num_win_q <= i_num_windows;
            win_cnt   <= '0;
            col_cnt   <= '0;
            o_busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            col_cnt <= col_last ? '0 : col_cnt + 3'd1;
            if (col_last) begin
              win_cnt <= win_cnt + WIN_CNT_WIDTH'(1);
              if (win_last) begin
                state <= ST_DRAIN;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (res_take && !s1_valid) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture the accepted column with its window position.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_4X3X3;
      s1_img   <= '0;
      s1_wgt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= col_cnt == '0;
        s1_last  <= col_last;
        s1_mode  <= mode_q;
        s1_img   <= i_img_column;
        s1_wgt   <= i_wgt_column;
      end
    end
  end

  MAC_column #(
    .DATA_WIDTH       (DATA_WIDTH),
    .COLUMN_NUM       (COLUMN_NUM),
    .COLUMN_OUT_WIDTH (CW)
  ) u_mac_column (
    .img  (s1_img),
    .wgt  (s1_wgt),
    .mode (s1_mode),
    .psum (psum)
  );

  assign psum_ext = {{(ACC_WIDTH-CW){psum[CW-1]}}, psum};
  assign acc_sum  = s1_first ? psum_ext : acc + psum_ext;

  // Stage 2: accumulate and publish the window sum on its last column.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc         <= '0;
      o_acc       <= '0;
      o_acc_valid <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= acc_sum;
      end
      if (s1_valid && s1_last) begin
        o_acc       <= acc_sum;
        o_acc_valid <= 1'b1;
      end else if (res_take) begin
        o_acc_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_column_seq.sv
// Randomised scoreboard bench for mac_column_seq.
// Expected window sums come from a plain arithmetic model of the job.
module tb_mac_column_seq;

  localparam int DW = 8;
  localparam int CN = 6;
  localparam int AW = 22;
  localparam int WW = 8;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [1:0]        i_mode = '0;
  logic [WW-1:0]     i_num_windows = '0;
  logic              i_col_valid = 1'b0;
  logic              o_col_ready;
  logic [DW*CN-1:0]  i_img_column = '0;
  logic [DW*CN-1:0]  i_wgt_column = '0;
  logic              o_acc_valid;
  logic              i_acc_ready = 1'b1;
  logic [AW-1:0]     o_acc;
  logic              o_busy;
  logic              o_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int done_seen = 0;
  int hold_cnt = 0;
  bit rdy_rand = 1'b0;
  bit pend = 1'b0;
  logic [AW-1:0] pend_val = '0;
  int exp_v;

  int k_tab[4] = '{3, 4, 5, 6};
  int r_tab[4] = '{6, 4, 5, 6};

  mac_column_seq #(
    .DATA_WIDTH    (DW),
    .COLUMN_NUM    (CN),
    .ACC_WIDTH     (AW),
    .WIN_CNT_WIDTH (WW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .i_num_windows (i_num_windows),
    .i_col_valid   (i_col_valid),
    .o_col_ready   (o_col_ready),
    .i_img_column  (i_img_column),
    .i_wgt_column  (i_wgt_column),
    .o_acc_valid   (o_acc_valid),
    .i_acc_ready   (i_acc_ready),
    .o_acc         (o_acc),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Result consumer: optional hold on the first result, else random or always ready.
  always @(posedge i_clk) begin
    #1;
    if (hold_cnt > 0 && o_acc_valid) begin
      i_acc_ready = 1'b0;
      hold_cnt--;
    end else if (rdy_rand) begin
      i_acc_ready = 1'($urandom % 2);
    end else begin
      i_acc_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each consumed result and checks holds.
  always @(negedge i_clk) begin
    if (i_rst) begin
      pend = 1'b0;
    end else begin
      if (o_done) done_seen++;
      if (pend) begin
        chk("hold_valid", 64'(o_acc_valid), 1);
        chk("hold_acc", 64'(o_acc), 64'(pend_val));
      end
      if (o_acc_valid && !i_acc_ready)
        chk("col_ready_stall", 64'(o_col_ready), 0);
      if (o_acc_valid && i_acc_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %0d expected none",
                   $signed(o_acc));
        end else begin
          exp_v = exp_q.pop_front();
          chk("acc", 64'($signed(o_acc)), 64'(exp_v));
        end
      end
      pend = o_acc_valid && !i_acc_ready;
      pend_val = o_acc;
    end
  end

  task automatic send_col(input logic [DW*CN-1:0] img,
                          input logic [DW*CN-1:0] wgt);
    int n = 0;
    bit ok = 1'b0;
    i_col_valid  = 1'b1;
    i_img_column = img;
    i_wgt_column = wgt;
    while (!ok && n < 200) begin
      @(negedge i_clk);
      ok = o_col_ready;
      n++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL col_accept_timeout: got no ready in %0d cycles", n);
    end
    @(posedge i_clk);
    #1;
    i_col_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d0);
    int n = 0;
    while (o_busy && n < 1000) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL job_timeout: busy after %0d cycles", n);
    end
    #1;
    chk("done_pulses", 64'(done_seen - d0), 1);
    chk("queue_empty", 64'(exp_q.size()), 0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_job(input int mode, input int nwin, input int gap,
                         input bit fixed, input logic [DW-1:0] fimg,
                         input logic [DW-1:0] fwgt, input bit poke,
                         input bit lat);
    int k;
    int r;
    int sum;
    int d0;
    logic [DW*CN-1:0] img;
    logic [DW*CN-1:0] wgt;
    k  = k_tab[mode];
    r  = r_tab[mode];
    d0 = done_seen;
    i_start       = 1'b1;
    i_mode        = 2'(mode);
    i_num_windows = WW'(nwin);
    @(posedge i_clk);
    #1;
    i_start       = 1'b0;
    i_mode        = 2'($urandom);
    i_num_windows = WW'($urandom);
    for (int w = 0; w < nwin; w++) begin
      sum = 0;
      for (int c = 0; c < k; c++) begin
        for (int e = 0; e < CN; e++) begin
          img[e*DW +: DW] = fixed ? fimg : DW'($urandom);
          wgt[e*DW +: DW] = fixed ? fwgt : DW'($urandom);
          if (e < r)
            sum += int'(img[e*DW +: DW]) * int'($signed(wgt[e*DW +: DW]));
        end
        if (c == k - 1) exp_q.push_back(sum);
        if (poke && w == 0 && c == 1) begin
          i_start       = 1'b1;
          i_mode        = 2'b00;
          i_num_windows = WW'(5);
        end
        send_col(img, wgt);
        i_start = 1'b0;
        if (lat && w == nwin - 1 && c == k - 1) begin
          @(negedge i_clk);
          chk("lat_cycle1_valid", 64'(o_acc_valid), 0);
          @(negedge i_clk);
          chk("lat_cycle2_valid", 64'(o_acc_valid), 1);
          @(negedge i_clk);
          chk("done_after_consume", 64'(o_done), 1);
        end
        if (gap == 1 || (gap == 2 && ($urandom % 2) == 1)) begin
          @(posedge i_clk);
          #1;
        end
      end
    end
    wait_idle(d0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [DW*CN-1:0] img;
    logic [DW*CN-1:0] wgt;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_acc_valid", 64'(o_acc_valid), 0);
    chk("rst_col_ready", 64'(o_col_ready), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_done", 64'(o_done), 0);
    chk("rst_acc", 64'(o_acc), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // 4x4, one window, img 1 x wgt 2, latency and done timing.
    run_job(1, 1, 0, 1'b1, 8'd1, 8'd2, 1'b0, 1'b1);

    // 6x6, three windows, extreme values, first result held back.
    hold_cnt = 5;
    run_job(3, 3, 0, 1'b1, 8'd255, 8'h80, 1'b0, 1'b0);
    hold_cnt = 0;

    // 4-3x3, two windows, valid on alternate cycles.
    run_job(0, 2, 1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Zero-window start is ignored.
    d0 = done_seen;
    i_start       = 1'b1;
    i_mode        = 2'b01;
    i_num_windows = '0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      chk("zero_win_busy", 64'(o_busy), 0);
      chk("zero_win_ready", 64'(o_col_ready), 0);
    end
    chk("zero_win_done", 64'(done_seen - d0), 0);
    @(posedge i_clk);
    #1;

    // Start pulse during RUN must not disturb the job.
    run_job(2, 2, 0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);

    // Reset after 2 of 5 columns aborts the job.
    d0 = done_seen;
    i_start       = 1'b1;
    i_mode        = 2'b10;
    i_num_windows = WW'(1);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int e = 0; e < CN; e++) begin
        img[e*DW +: DW] = 8'd200;
        wgt[e*DW +: DW] = 8'd100;
      end
      send_col(img, wgt);
    end
    i_rst = 1'b1;
    #1;
    chk("mid_rst_acc_valid", 64'(o_acc_valid), 0);
    chk("mid_rst_col_ready", 64'(o_col_ready), 0);
    chk("mid_rst_busy", 64'(o_busy), 0);
    chk("mid_rst_done", 64'(o_done), 0);
    chk("mid_rst_acc", 64'(o_acc), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("mid_rst_no_done", 64'(done_seen - d0), 0);
    @(posedge i_clk);
    #1;
    run_job(2, 1, 0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Random jobs with random gaps and random backpressure.
    rdy_rand = 1'b1;
    for (int j = 0; j < 6; j++) begin
      run_job(int'($urandom % 4), 1 + int'($urandom % 4), 2,
              1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
    end
    rdy_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
